// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: opcodes, FSM state encoding and port ids shared by the SPI memory arbiter
package spi_arb_pkg;
  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, DONE, GAP} state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 SCLK divider with MSB-first shift-out/shift-in; o_last flags the final cycle of a phase
module spi_shift_engine #(
  parameter int SCK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_nbits,
  input  logic [23:0] i_dout,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_last,
  output logic [15:0] o_rdata
);
  logic        r_busy, r_sclk;
  logic [4:0]  r_cnt;
  logic [15:0] r_div, r_in;
  logic [23:0] r_sh;
  logic        w_tick;
  assign w_tick  = r_busy && r_div == 16'(SCK_HALF - 1);
  assign o_last  = w_tick && r_sclk && r_cnt == 5'd1;
  assign o_sclk  = r_sclk;
  assign o_mosi  = r_sh[23];
  assign o_rdata = r_in;
  // a start on the last cycle of a phase chains the next phase with no idle bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_cnt  <= '0;
      r_div  <= '0;
      r_sh   <= '0;
      r_in   <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_cnt  <= i_nbits;
      r_sh   <= i_dout;
    end else if (r_busy) begin
      r_div <= w_tick ? '0 : r_div + 16'd1;
      if (w_tick) begin
        r_sclk <= !r_sclk;
        if (!r_sclk) r_in <= {r_in[14:0], i_miso};
        else begin
          r_sh   <= {r_sh[22:0], 1'b0};
          r_cnt  <= r_cnt - 5'd1;
          r_busy <= r_cnt != 5'd1;
        end
      end
    end
  end
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin share of one SPI memory bus between instruction fetch and a byte data port
module spi_mem_arbiter #(
  parameter int          SCK_HALF   = 1,
  parameter int          CS_GAP     = 2,
  parameter logic [23:0] FETCH_BASE = 24'h000000,
  parameter logic [23:0] DATA_BASE  = 24'h010000,
  parameter int          DADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [15:0]        fetch_addr,
  output logic               fetch_ready,
  output logic [15:0]        fetch_data,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [DADDR_W-1:0] data_addr,
  input  logic [7:0]         data_wdata,
  output logic               data_ready,
  output logic [7:0]         data_rdata,
  output logic               spi_cs,
  output logic               spi_sclk,
  output logic               spi_io0_o,
  output logic               spi_io0_oe,
  input  logic               spi_io1_i
);
  import spi_arb_pkg::*;
  state_t      r_state, w_next;
  port_t       r_last_grant, r_port;
  logic        r_we, r_fetch_ready, r_data_ready;
  logic [23:0] r_addr, w_addr, w_dout;
  logic [7:0]  r_wdata, r_gap, r_data_rdata;
  logic [15:0] r_fetch_data, w_rdata;
  logic        w_any, w_pick_data, w_start, w_last, w_fin, w_mosi;
  logic [4:0]  w_nbits;
  assign w_any       = fetch_req | data_req;
  assign w_pick_data = data_req & (~fetch_req | r_last_grant == PORT_FETCH);
  assign w_addr      = w_pick_data ? DATA_BASE + 24'(data_addr) : FETCH_BASE + 24'({fetch_addr, 1'b0});
  assign w_fin       = w_last & (r_state == RDATA | r_state == WDATA);
  assign spi_cs      = r_state inside {IDLE, DONE, GAP};
  assign spi_io0_oe  = r_state inside {CMD, ADDR, WDATA};
  assign spi_io0_o   = spi_io0_oe & w_mosi;
  assign fetch_ready = r_fetch_ready;
  assign data_ready  = r_data_ready;
  assign fetch_data  = r_fetch_data;
  assign data_rdata  = r_data_rdata;
  spi_shift_engine #(.SCK_HALF(SCK_HALF)) u_eng (
    .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_nbits(w_nbits), .i_dout(w_dout),
    .i_miso(spi_io1_i), .o_sclk(spi_sclk), .o_mosi(w_mosi), .o_last(w_last), .o_rdata(w_rdata)
  );
  // next state and the shift-engine load for the phase that starts at the coming edge
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_nbits = 5'd8;
    w_dout  = '0;
    case (r_state)
      IDLE: if (w_any) begin
        w_next  = CMD;
        w_start = 1'b1;
        w_dout  = {(w_pick_data & data_we) ? SPI_OP_WRITE : SPI_OP_READ, 16'h0};
      end
      CMD: if (w_last) begin
        w_next  = ADDR;
        w_start = 1'b1;
        w_nbits = 5'd24;
        w_dout  = r_addr;
      end
      ADDR: if (w_last) begin
        w_next  = r_we ? WDATA : RDATA;
        w_start = 1'b1;
        w_nbits = (!r_we && r_port == PORT_FETCH) ? 5'd16 : 5'd8;
        w_dout  = r_we ? {r_wdata, 16'h0} : 24'h0;
      end
      RDATA, WDATA: if (w_last) w_next = DONE;
      DONE: w_next = CS_GAP > 1 ? GAP : IDLE;
      GAP: if (r_gap == 8'd0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, grant latches, gap counter, ready pulses and returned data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_grant  <= PORT_FETCH;
      r_port        <= PORT_FETCH;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_gap         <= '0;
      r_fetch_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_fetch_data  <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_port       <= w_pick_data ? PORT_DATA : PORT_FETCH;
        r_last_grant <= w_pick_data ? PORT_DATA : PORT_FETCH;
        r_we         <= w_pick_data & data_we;
        r_addr       <= w_addr;
        r_wdata      <= data_wdata;
      end
      if (r_state == DONE) r_gap <= 8'(CS_GAP - 2);
      else if (r_state == GAP) r_gap <= r_gap - 8'd1;
      r_fetch_ready <= w_fin & r_port == PORT_FETCH;
      r_data_ready  <= w_fin & r_port == PORT_DATA;
      if (w_fin & r_port == PORT_FETCH) r_fetch_data <= w_rdata;
      if (w_fin & r_port == PORT_DATA & ~r_we) r_data_rdata <= w_rdata[7:0];
    end
  end
endmodule
